// File: rtl/score_pkg.sv
// Purpose : shared types and constants for the score keeper (FSM state, BCD digit, saturation points).
// Latency : n/a (package only).
// Backpressure : n/a.
package score_pkg;

   // Two-state service FSM: IDLE picks one pending event, ADD pumps score increments.
   typedef enum logic {
      IDLE = 1'b0,
      ADD  = 1'b1
   } state_t;

   // One packed BCD digit.
   typedef logic [3:0] bcd_t;

   localparam bcd_t        BCD_MAX_DIGIT = 4'd9;
   localparam logic [15:0] SCORE_SAT     = 16'h9999;
   localparam logic [7:0]  COMBO_SAT     = 8'h99;

   // Multiplier from the combo tens digit: tens+1, clipped at max_mult.
   function automatic logic [2:0] calc_mult(input bcd_t tens, input int unsigned max_mult);
      int unsigned m;
      m = 32'(tens) + 32'd1;
      if (m > max_mult) begin
         m = max_mult;
      end
      return m[2:0];
   endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_inc.sv
// Purpose : single BCD digit incrementer, chained through carry to build multi-digit counters.
// Latency : combinational.
// Backpressure : none.
// Ports   : digit/carry_in -> digit_out/carry_out (carry_out only when digit is 9 and carry_in set).
module bcd_digit_inc
   import score_pkg::*;
(
   input  bcd_t digit,
   input  logic carry_in,
   output bcd_t digit_out,
   output logic carry_out
);

   logic at_max;

   assign at_max    = (digit == BCD_MAX_DIGIT);
   assign carry_out = carry_in & at_max;

   always_comb begin
      digit_out = digit;
      if (carry_in) begin
         digit_out = at_max ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Purpose : collects per-lane hit/miss pulses, keeps BCD score, BCD combo and the combo multiplier.
// Latency : hit at E0 -> combo at E1, score +1 on E2..E(1+m); miss at E0 -> combo cleared at E1.
// Backpressure : none upstream; events queue in one pending bit per lane/class, a same-lane
//                repeat before service is lost and flagged on the sticky dropped output.
// Ports   : clk/reset(async, high), game_start (sync clear), hit/miss[NUM_LANES] pulses;
//           score_bcd[15:0], combo_bcd[7:0], mult[2:0], busy, dropped.
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int MAX_MULT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 game_start,
   input  logic [NUM_LANES-1:0] hit,
   input  logic [NUM_LANES-1:0] miss,
   output logic [15:0]          score_bcd,
   output logic [7:0]           combo_bcd,
   output logic [2:0]           mult,
   output logic                 busy,
   output logic                 dropped
);

   localparam logic [NUM_LANES-1:0] LANE_ONE = NUM_LANES'(1);

   state_t               state_q;
   logic [2:0]           add_cnt_q;
   logic [15:0]          score_q;
   logic [7:0]           combo_q;
   logic [NUM_LANES-1:0] pend_hit_q,  pend_hit_d;
   logic [NUM_LANES-1:0] pend_miss_q, pend_miss_d;
   logic                 dropped_q;

   logic [NUM_LANES-1:0] svc_hit, svc_miss;
   logic                 drop_evt;
   logic [15:0]          score_inc;
   logic [7:0]           combo_inc;
   logic [4:0]           score_c;
   logic [2:0]           combo_c;
   logic                 score_at_sat;
   logic                 combo_at_sat;

   // ---------------------------------------------------------------
   // BCD incrementers: carry into digit 0 is always set, so the final
   // carry-out is high exactly when every digit is 9 (saturation).
   // ---------------------------------------------------------------
   assign score_c[0] = 1'b1;
   assign combo_c[0] = 1'b1;

   for (genvar g = 0; g < 4; g++) begin : g_score_digit
      bcd_digit_inc u_inc (
         .digit     (score_q[4*g +: 4]),
         .carry_in  (score_c[g]),
         .digit_out (score_inc[4*g +: 4]),
         .carry_out (score_c[g+1])
      );
   end

   for (genvar g = 0; g < 2; g++) begin : g_combo_digit
      bcd_digit_inc u_inc (
         .digit     (combo_q[4*g +: 4]),
         .carry_in  (combo_c[g]),
         .digit_out (combo_inc[4*g +: 4]),
         .carry_out (combo_c[g+1])
      );
   end

   assign score_at_sat = score_c[4];
   assign combo_at_sat = combo_c[2];

   // ---------------------------------------------------------------
   // Service selection, IDLE only: hits beat misses, lowest lane first.
   // x & (~x + 1) isolates the lowest set bit.
   // ---------------------------------------------------------------
   always_comb begin
      svc_hit  = '0;
      svc_miss = '0;
      if (state_q == IDLE) begin
         if (|pend_hit_q) begin
            svc_hit = pend_hit_q & (~pend_hit_q + LANE_ONE);
         end else begin
            svc_miss = pend_miss_q & (~pend_miss_q + LANE_ONE);
         end
      end
   end

   // A pulse arriving on the same edge its bit is serviced is kept;
   // one arriving on a bit that stays pending is lost.
   assign pend_hit_d  = (pend_hit_q  & ~svc_hit)  | hit;
   assign pend_miss_d = (pend_miss_q & ~svc_miss) | miss;
   assign drop_evt    = |((hit  & pend_hit_q  & ~svc_hit) |
                          (miss & pend_miss_q & ~svc_miss));

   // Multiplier follows the live combo, so the value sampled at hit
   // service is the pre-increment one.
   assign mult = calc_mult(combo_q[7:4], MAX_MULT);

   // ---------------------------------------------------------------
   // State / counters
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         add_cnt_q   <= 3'd0;
         score_q     <= 16'h0000;
         combo_q     <= 8'h00;
         pend_hit_q  <= '0;
         pend_miss_q <= '0;
         dropped_q   <= 1'b0;
      end else if (game_start) begin
         state_q     <= IDLE;
         add_cnt_q   <= 3'd0;
         score_q     <= 16'h0000;
         combo_q     <= 8'h00;
         pend_hit_q  <= '0;
         pend_miss_q <= '0;
         dropped_q   <= 1'b0;
      end else begin
         pend_hit_q  <= pend_hit_d;
         pend_miss_q <= pend_miss_d;
         if (drop_evt) begin
            dropped_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (|svc_hit) begin
                  add_cnt_q <= mult;
                  if (!combo_at_sat) begin
                     combo_q <= combo_inc;
                  end
                  state_q <= ADD;
               end else if (|svc_miss) begin
                  combo_q <= 8'h00;
               end
            end
            ADD: begin
               // At 9999 the cycle is still spent, only the score holds.
               if (!score_at_sat) begin
                  score_q <= score_inc;
               end
               add_cnt_q <= add_cnt_q - 3'd1;
               if (add_cnt_q == 3'd1) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign score_bcd = score_q;
   assign combo_bcd = combo_q;
   assign busy      = (state_q != IDLE) | (|pend_hit_q) | (|pend_miss_q);
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_score_keeper.sv
// Purpose : directed self-checking bench for score_keeper.
// Latency : inputs driven 1ns after posedge, outputs sampled there as well.
// Backpressure : n/a.
module tb_score_keeper;

   logic        clk;
   logic        reset;
   logic        game_start;
   logic [3:0]  hit;
   logic [3:0]  miss;
   logic [15:0] score_bcd;
   logic [7:0]  combo_bcd;
   logic [2:0]  mult;
   logic        busy;
   logic        dropped;

   int errors;
   int checks;
   int cyc;

   score_keeper #(.NUM_LANES(4), .MAX_MULT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .game_start (game_start),
      .hit        (hit),
      .miss       (miss),
      .score_bcd  (score_bcd),
      .combo_bcd  (combo_bcd),
      .mult       (mult),
      .busy       (busy),
      .dropped    (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse a hit and wait (bounded) until the block is idle again.
   // cycles_o counts post-edge samples with busy high, i.e. 1 + multiplier.
   task automatic do_hit(input logic [3:0] lanes, output int cycles_o);
      hit = lanes;
      tick();
      hit = 4'b0000;
      cycles_o = 0;
      while (busy === 1'b1 && cycles_o < 64) begin
         cycles_o++;
         tick();
      end
      check("hit_settles", {15'd0, busy}, 16'd0);
   endtask

   task automatic pulse_game_start;
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      reset      = 1'b1;
      game_start = 1'b0;
      hit        = 4'b0000;
      miss       = 4'b0000;

      // ---- reset state ----
      #12;
      check("rst_score",   score_bcd,          16'h0000);
      check("rst_combo",   {8'd0, combo_bcd},  16'h0000);
      check("rst_mult",    {13'd0, mult},      16'd1);
      check("rst_busy",    {15'd0, busy},      16'd0);
      check("rst_dropped", {15'd0, dropped},   16'd0);
      reset = 1'b0;
      tick();

      // ---- single hit on lane 2 ----
      hit = 4'b0100;
      tick();                       // E0: captured
      hit = 4'b0000;
      check("s_e0_combo", {8'd0, combo_bcd}, 16'h0000);
      check("s_e0_busy",  {15'd0, busy},     16'd1);
      tick();                       // E1: serviced
      check("s_e1_combo", {8'd0, combo_bcd}, 16'h0001);
      check("s_e1_score", score_bcd,         16'h0000);
      tick();                       // E2: score increment
      check("s_e2_score", score_bcd,         16'h0001);
      check("s_e2_mult",  {13'd0, mult},     16'd1);
      tick();                       // E3
      check("s_e3_busy",  {15'd0, busy},     16'd0);

      // ---- multiplier ramp ----
      for (int i = 0; i < 9; i++) begin
         do_hit(4'b0001 << (i % 4), cyc);
      end
      check("ramp_combo", {8'd0, combo_bcd}, 16'h0010);
      check("ramp_score", score_bcd,         16'h0010);
      check("ramp_mult",  {13'd0, mult},     16'd2);
      do_hit(4'b1000, cyc);
      check("ramp11_cycles", 16'(cyc),        16'd3);
      check("ramp11_score",  score_bcd,       16'h0012);
      check("ramp11_combo",  {8'd0, combo_bcd}, 16'h0011);

      // ---- game_start overrides same-cycle hits ----
      game_start = 1'b1;
      hit        = 4'b1111;
      tick();
      game_start = 1'b0;
      hit        = 4'b0000;
      check("gs_score", score_bcd,         16'h0000);
      check("gs_combo", {8'd0, combo_bcd}, 16'h0000);
      check("gs_busy",  {15'd0, busy},     16'd0);
      check("gs_mult",  {13'd0, mult},     16'd1);

      // ---- simultaneous hits and a miss ----
      for (int i = 0; i < 5; i++) begin
         do_hit(4'b0010, cyc);
      end
      check("sim_pre_combo", {8'd0, combo_bcd}, 16'h0005);
      hit  = 4'b1010;
      miss = 4'b0001;
      tick();                       // E0
      hit  = 4'b0000;
      miss = 4'b0000;
      tick();                       // E1: lane1 hit
      check("sim_e1_combo", {8'd0, combo_bcd}, 16'h0006);
      check("sim_e1_score", score_bcd,         16'h0005);
      tick();                       // E2
      check("sim_e2_score", score_bcd,         16'h0006);
      tick();                       // E3: lane3 hit
      check("sim_e3_combo", {8'd0, combo_bcd}, 16'h0007);
      tick();                       // E4
      check("sim_e4_score", score_bcd,         16'h0007);
      tick();                       // E5: miss lane0
      check("sim_e5_combo", {8'd0, combo_bcd}, 16'h0000);
      check("sim_e5_score", score_bcd,         16'h0007);
      check("sim_e5_busy",  {15'd0, busy},     16'd0);

      // ---- same-lane collision ----
      pulse_game_start();
      hit = 4'b0001;
      tick();                       // E0: captured
      tick();                       // E1: serviced, new pulse survives
      check("col_e1_dropped", {15'd0, dropped}, 16'd0);
      tick();                       // E2: in ADD with bit pending -> lost
      check("col_e2_dropped", {15'd0, dropped}, 16'd1);
      hit = 4'b0000;
      cyc = 0;
      while (busy === 1'b1 && cyc < 64) begin
         cyc++;
         tick();
      end
      check("col_settle",    {15'd0, busy},     16'd0);
      check("col_sticky",    {15'd0, dropped},  16'd1);
      check("col_combo",     {8'd0, combo_bcd}, 16'h0002);
      check("col_score",     score_bcd,         16'h0002);
      pulse_game_start();
      check("col_gs_dropped", {15'd0, dropped}, 16'd0);

      // ---- saturation ----
      for (int i = 0; i < 30; i++) begin
         do_hit(4'b0001 << (i % 4), cyc);
      end
      check("sat30_score", score_bcd,         16'h0060);
      check("sat30_combo", {8'd0, combo_bcd}, 16'h0030);
      check("sat30_mult",  {13'd0, mult},     16'd4);
      for (int i = 0; i < 2484; i++) begin
         do_hit(4'b0100, cyc);
      end
      check("sat_pre_score", score_bcd,         16'h9996);
      check("sat_pre_combo", {8'd0, combo_bcd}, 16'h0099);
      do_hit(4'b0100, cyc);
      check("sat_cycles",    16'(cyc),          16'd5);
      check("sat_score",     score_bcd,         16'h9999);
      do_hit(4'b1000, cyc);
      check("sat_hold_cycles", 16'(cyc),        16'd5);
      check("sat_hold_score",  score_bcd,       16'h9999);
      check("sat_hold_combo",  {8'd0, combo_bcd}, 16'h0099);

      // ---- asynchronous reset in the middle of ADD ----
      hit = 4'b0001;
      tick();                       // E0
      hit = 4'b0000;
      tick();                       // E1: ADD with four increments queued
      tick();                       // E2: still in ADD
      check("mid_busy_before", {15'd0, busy}, 16'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_score",   score_bcd,         16'h0000);
      check("async_combo",   {8'd0, combo_bcd}, 16'h0000);
      check("async_mult",    {13'd0, mult},     16'd1);
      check("async_busy",    {15'd0, busy},     16'd0);
      check("async_dropped", {15'd0, dropped},  16'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_score", score_bcd, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream consumer of the four light columns.
- Collects per-lane hit pulses (row `scored`) and per-lane miss pulses (a passed note or an empty press, as flagged by the light column).
- Maintains the BCD score, BCD combo and score multiplier that drive the HEX displays.
- Serialises simultaneous lane events through a pending register and a small FSM, so only a single-digit BCD incrementer is needed.

Parameters:
- NUM_LANES, 4, number of arrow columns feeding the block.
- MAX_MULT, 4, multiplier ceiling (1..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset; clears all state.
- game_start  in  1  synchronous clear of score/combo/pending, one-cycle pulse.
- hit  in  NUM_LANES  per-lane one-cycle hit pulse.
- miss  in  NUM_LANES  per-lane one-cycle miss/empty-press pulse.
- score_bcd  out  16  four BCD digits, [15:12] thousands.
- combo_bcd  out  8  two BCD digits.
- mult  out  3  current multiplier, 1..MAX_MULT.
- busy  out  1  high when FSM not in IDLE or any pending bit set.
- dropped  out  1  sticky: an event was lost to a same-lane collision.

Behaviour:
- Reset values (async, immediate):
  - score_bcd=0, combo_bcd=0, mult=1, busy=0, dropped=0.
  - pending_hit=0, pending_miss=0, state=IDLE, add_cnt=0.
- game_start:
  - Same clear as reset, on the clock edge.
  - Overrides any hit/miss pulse in the same cycle.
  - Also clears dropped.
- Pending capture, every edge:
  - pending_x_next = (pending_x & ~svc_x) | x.
  - A newly arriving pulse survives a same-edge service of its bit.
  - If x[i] is high while pending_x[i] is set and not being serviced, dropped goes to 1 (sticky).
- Service priority, evaluated in IDLE only:
  - All hits before misses.
  - Within a class, lowest lane index first.
  - Exactly one bit is serviced per IDLE cycle.
- FSM states: IDLE, ADD.
  - IDLE, pending hit selected:
    - Clear that bit.
    - add_cnt <= mult, using the multiplier from the pre-increment combo.
    - combo_bcd <= combo+1, saturating at 99.
    - Go to ADD.
  - IDLE, pending miss selected (no hit pending):
    - Clear that bit.
    - combo_bcd <= 0.
    - Stay in IDLE.
  - IDLE, nothing pending: hold.
  - ADD:
    - score_bcd <= score_bcd+1 in BCD, carry rippling across digits, saturating at 9999 (no wrap).
    - add_cnt decrements.
    - When add_cnt==1 at the edge, return to IDLE.
    - Pending bits are not serviced while in ADD.
- Multiplier: mult = min(combo tens digit + 1, MAX_MULT), combinational from combo_bcd.
  - combo 0–9 → 1; 10–19 → 2; 20–29 → 3; ≥30 → 4.
- Latency:
  - A hit pulse registered at edge E0 is serviced at E1.
  - Score increments on edges E2..E(1+m).
  - Final score is visible after E(1+m), where m is the multiplier at service.
  - A miss clears combo at E1.
- Score saturation: once at 9999, ADD cycles still consume add_cnt but the score does not change.
- Simultaneous hit and miss on the same lane in one cycle: both bits are captured; the hit is serviced first.

Decomposition:
- Package score_pkg:
  - state enum {IDLE, ADD}.
  - BCD digit typedef (logic [3:0]).
  - Constants BCD_MAX_DIGIT=9 and SCORE_SAT=16'h9999.
- Sub-module bcd_digit_inc:
  - Inputs: digit, carry_in.
  - Outputs: digit_out, carry_out.
  - Instantiated four times for the score and twice for the combo.

Test Plan:
- Reset mid-ADD: assert reset asynchronously while state=ADD.
  - → all outputs zero, mult=1 immediately, without waiting for a clock edge.
- Single hit on lane 2 from reset.
  - → combo=01 one edge after capture; score=0001 after E2; mult stays 1; busy low by E3.
- Multiplier ramp: 10 isolated hits.
  - → combo=10, mult=2.
  - 11th hit → score=0012, with 2 ADD cycles observed for that hit.
- Simultaneous hit=4'b1010 and miss=4'b0001 in one cycle, combo=05.
  - → lane1 hit serviced first, then lane3 hit.
  - Then miss → combo=00.
  - Final combo=00, score +2.
- Collision: hit[0] pulsed while pending_hit[0] is set during ADD.
  - → dropped=1 and stays 1.
  - game_start clears dropped to 0.
- Saturation: preload score near 9998 via hits at mult=4.
  - → score holds at 9999, no wrap to 0000.
